// File: rtl/tile_fb_writer.sv
// Tile-indexed RGB332 frame buffer with a single write port, a bulk fill engine
// and a registered display read port (latency 1, read-before-write).
module tile_fb_writer #(
  parameter int HBLK = 32,
  parameter int VBLK = 24,
  parameter int SIZE = 768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [5:0]  wr_x,
  input  logic [4:0]  wr_y,
  input  logic [7:0]  wr_color,
  input  logic        clr_req,
  input  logic [7:0]  clr_color,
  output logic        busy,
  input  logic [15:0] rd_addr,
  output logic [7:0]  rd_color,
  output logic        err
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [7:0]  col_q, col_d;
  logic        err_q, err_d;
  logic [7:0]  rd_color_q;

  logic [7:0]  mem [SIZE];
  logic        mem_we;
  logic [9:0]  mem_wa;
  logic [7:0]  mem_wd;

  logic [9:0]  widx;
  logic        wr_in_range;
  logic        rd_in_range;

  // Out-of-range writes never reach memory, so truncating the index is safe.
  assign widx        = 10'(int'(wr_y) * HBLK + int'(wr_x));
  assign wr_in_range = (int'(wr_x) < HBLK) && (int'(wr_y) < VBLK);
  assign rd_in_range = rd_addr < 16'(SIZE);

  assign wr_ready = (state_q == IDLE) && !clr_req;
  assign busy     = (state_q == CLEAR);
  assign err      = err_q;
  assign rd_color = rd_color_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    mem_wa  = cnt_q;
    mem_wd  = col_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          col_d   = clr_color;
          cnt_d   = '0;
          state_d = CLEAR;
        end else if (wr_valid) begin
          if (wr_in_range) begin
            mem_we = 1'b1;
            mem_wa = widx;
            mem_wd = wr_color;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        mem_we = 1'b1;
        if (cnt_q == 10'(SIZE - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Reset lands in CLEAR so every power-up starts from a black buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      col_q      <= 8'h00;
      err_q      <= 1'b0;
      rd_color_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      col_q      <= col_d;
      err_q      <= err_d;
      rd_color_q <= rd_in_range ? mem[rd_addr[9:0]] : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

endmodule

// File: tb/tb_tile_fb_writer.sv
// Directed bench for tile_fb_writer: reset fill, writes, range errors,
// clear with contention, read-before-write and reset during a fill.
module tb_tile_fb_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [5:0]  wr_x;
  logic [4:0]  wr_y;
  logic [7:0]  wr_color;
  logic        clr_req;
  logic [7:0]  clr_color;
  logic        busy;
  logic [15:0] rd_addr;
  logic [7:0]  rd_color;
  logic        err;

  int errors = 0;
  int checks = 0;
  int n;

  tile_fb_writer #(.HBLK(32), .VBLK(24), .SIZE(768)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
    .clr_req(clr_req), .clr_color(clr_color), .busy(busy),
    .rd_addr(rd_addr), .rd_color(rd_color), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts rising edges until busy drops, bounded so a stuck fill cannot hang.
  task automatic wait_idle(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      #1;
    end while (busy && cyc < 2000);
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    chk(tag, {24'h0, rd_color}, {24'h0, exp});
  endtask

  task automatic write1(input logic [5:0] x, input logic [4:0] y, input logic [7:0] c);
    @(negedge clk);
    wr_valid = 1'b1; wr_x = x; wr_y = y; wr_color = c;
    #1 chk("wr_ready_idle", {31'h0, wr_ready}, 32'd1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_color = '0;
    clr_req = 1'b0; clr_color = '0; rd_addr = '0;
    #3;
    chk("rst_busy",     {31'h0, busy},     32'd1);
    chk("rst_wr_ready", {31'h0, wr_ready}, 32'd0);
    chk("rst_err",      {31'h0, err},      32'd0);
    chk("rst_rd_color", {24'h0, rd_color}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_idle(n);
    chk("reset_fill_cycles", n, 32'd768);

    rd_chk("rd_0_after_reset",   16'd0,   8'h00);
    rd_chk("rd_383_after_reset", 16'd383, 8'h00);
    rd_chk("rd_767_after_reset", 16'd767, 8'h00);

    // Plain write at (5,2) -> index 69.
    write1(6'd5, 5'd2, 8'hE0);
    chk("err_after_good_write", {31'h0, err}, 32'd0);
    rd_chk("rd_69", 16'd69, 8'hE0);

    // Out-of-range writes: handshake completes, err pulses once.
    write1(6'd32, 5'd0, 8'h55);
    chk("err_x_oob", {31'h0, err}, 32'd1);
    @(negedge clk);
    chk("err_x_oob_clears", {31'h0, err}, 32'd0);
    write1(6'd0, 5'd24, 8'h66);
    chk("err_y_oob", {31'h0, err}, 32'd1);
    @(negedge clk);
    chk("err_y_oob_clears", {31'h0, err}, 32'd0);
    rd_chk("rd_0_after_oob",   16'd0,   8'h00);
    rd_chk("rd_768_oob_addr",  16'd768, 8'h00);

    // Last in-range tile (31,23) -> index 767.
    write1(6'd31, 5'd23, 8'h77);
    rd_chk("rd_767_last_tile", 16'd767, 8'h77);

    // Clear with a simultaneous write; write must wait for the fill.
    @(negedge clk);
    clr_req = 1'b1; clr_color = 8'h03;
    wr_valid = 1'b1; wr_x = 6'd1; wr_y = 5'd0; wr_color = 8'hAA;
    #1 chk("clr_blocks_ready", {31'h0, wr_ready}, 32'd0);
    @(negedge clk);
    chk("clr_busy", {31'h0, busy}, 32'd1);
    clr_req = 1'b1; clr_color = 8'hF0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
      clr_req = 1'b0;
      clr_color = 8'h5A;
      if (busy && n == 100) chk("ready_low_in_clear", {31'h0, wr_ready}, 32'd0);
    end while (busy && n < 2000);
    chk("clear_cycles", n, 32'd768);
    chk("ready_after_clear", {31'h0, wr_ready}, 32'd1);
    @(posedge clk);
    #1 wr_valid = 1'b0;
    rd_chk("rd_0_cleared",   16'd0,   8'h03);
    rd_chk("rd_1_written",   16'd1,   8'hAA);
    rd_chk("rd_69_cleared",  16'd69,  8'h03);
    rd_chk("rd_767_cleared", 16'd767, 8'h03);

    // Read and write of index 100 (4,3) on the same edge.
    @(negedge clk);
    rd_addr = 16'd100;
    wr_valid = 1'b1; wr_x = 6'd4; wr_y = 5'd3; wr_color = 8'h1C;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("rbw_old", {24'h0, rd_color}, 32'h03);
    @(negedge clk);
    chk("rbw_new", {24'h0, rd_color}, 32'h1C);

    // Reset in the middle of an FF fill.
    @(negedge clk);
    rd_addr = 16'd1;
    clr_req = 1'b1; clr_color = 8'hFF;
    @(posedge clk);
    #1 clr_req = 1'b0;
    repeat (400) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midfill_rst_busy",  {31'h0, busy},     32'd1);
    chk("midfill_rst_rdcol", {24'h0, rd_color}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_idle(n);
    chk("refill_cycles", n, 32'd768);
    rd_chk("rd_0_refill",   16'd0,   8'h00);
    rd_chk("rd_100_refill", 16'd100, 8'h00);
    rd_chk("rd_767_refill", 16'd767, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
